bit_op_ctrl: RTL and testbench
==============================

Name: bit_op_ctrl

Overview:
- Initiator side of the bit-memory port: executes 8051 bit instructions (SETB, CLR, CPL, MOV C/bit, ANL/ORL C, JBC) against a bit-addressable memory.
- Drives the memory's CS (active-low), RW (H read, L write), addr and din, and samples its registered dout.
- Sits between the instruction decoder and the bit memory; the decoder issues one request and waits for done.

Parameters:
- ADDRWIDTH, 3, bit-address width; must equal the memory's ADDRWIDTH.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  1  start request; sampled only in IDLE.
- op  in  3  operation code, latched with req.
- bit_addr  in  ADDRWIDTH  target bit address, latched with req.
- c_in  in  1  current carry flag, latched with req.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- c_out  out  1  resulting carry; valid while done=1, held until the next done.
- bit_val  out  1  bit value read; valid while done=1 for read ops, held otherwise.
- mem_CS  out  1  chip select to memory, low = selected.
- mem_RW  out  1  H read, L write.
- mem_addr  out  ADDRWIDTH  bit address to memory.
- mem_din  out  1  write data to memory.
- mem_dout  in  1  memory read data; registered by the memory at the read edge.

Behaviour:
- Opcodes:
  - 000 SETB: bit←1.
  - 001 CLR: bit←0.
  - 010 CPL: bit←~bit.
  - 011 MOV C,bit: c_out←bit, no write.
  - 100 MOV bit,C: bit←c_in, no read.
  - 101 ANL C,bit: c_out←c_in&bit.
  - 110 ORL C,bit: c_out←c_in|bit.
  - 111 JBC: bit_val←bit, then bit←0.
  - Opcodes that do not modify carry set c_out←latched c_in.
- States: IDLE, RD, EX, WR, DN. The FSM is Moore; all mem_* outputs decode from the state register and the latched operands only.
- IDLE:
  - mem_CS=1, mem_RW=1.
  - req=1 at an edge latches op, bit_addr and c_in.
  - Next state is WR for op 100; RD otherwise.
- RD: mem_CS=0, mem_RW=1, mem_addr=latched addr. The memory registers dout at the RD→EX edge. Next state EX.
- EX:
  - mem_CS=1; mem_dout is valid this cycle.
  - Compute wdata, c_out and bit_val; register them at the exit edge.
  - Next state WR for ops 000, 001, 010, 111; DN otherwise.
  - mem_dout equal to 0, x or z is treated as 0; only logic 1 counts as 1.
- WR:
  - mem_CS=0, mem_RW=0, mem_addr=latched addr, mem_din=wdata.
  - For op 100, wdata=c_in.
  - The memory writes at the WR exit edge. Next state DN.
- DN: done=1 for exactly one cycle, busy=1, mem_CS=1. Next state IDLE. req in DN is ignored.
- Latency from the req-accept edge E0 to done high:
  - 3 cycles for read-only ops (done in the cycle after E2).
  - 4 cycles for read-modify-write ops.
  - 2 cycles for op 100.
  - Back-to-back: earliest next accept is the edge ending DN+IDLE, so minimum one IDLE cycle between operations.
- req while busy=1 is ignored, not queued. Operands stay stable from the latch until DN.
- Reset values: state IDLE, busy=0, done=0, c_out=0, bit_val=0, mem_CS=1, mem_RW=1, mem_addr=0, mem_din=0, all operand latches 0.
- Reset mid-operation: the next edge forces IDLE and CS deasserts.
  - If rst is asserted during a WR cycle, the write still lands at that edge, because the memory has no reset. This is accepted behaviour.
  - If rst is asserted in RD or EX, no write occurs.
  - No done pulse is produced for an aborted op.
- The FSM never drives mem_CS=0 in two consecutive cycles with different RW except RD→(EX)→WR. CS is always released in EX.

Decomposition:
- Package bit_op_pkg holds:
  - Opcode localparams (OP_SETB..OP_JBC).
  - State encoding (IDLE..DN).
  - The CS_SEL=0 / RW_READ=1 / RW_WRITE=0 constants shared with the memory side.
- Sub-module bit_op_alu: purely combinational. Inputs op, rd_bit, c_in; outputs wdata, c_out, needs_read, needs_write. Instantiated once; the FSM uses needs_read/needs_write for branching.

Test Plan:
- SETB at addr 5 (preloaded 0) → mem_CS=0/RW=1 at cycle E0+1; write of 1 to addr 5 at edge E3; done high cycle E3+; subsequent MOV C,bit addr 5 returns c_out=1.
- CPL addr 2 twice starting from 1 → value 0 then 1. ANL C,bit with c_in=1 on the 0 state → c_out=0; ORL C,bit c_in=0 on the 1 state → c_out=1.
- MOV bit,C c_in=1 addr 7 → no read cycle (mem_RW never 1 with CS=0); write at E1; done after E1.
- JBC addr 3 holding 1 → bit_val=1, c_out=c_in, addr 3 reads 0 afterwards. JBC on a 0 bit still writes 0.
- req held high continuously → ops accepted only in IDLE, done pulses spaced by latency+1; req pulses during busy are dropped.
- rst asserted in EX of SETB → returns IDLE, mem_CS=1, no write (bit unchanged), no done. rst asserted during WR → write lands, state IDLE, done never pulses.

Source files
------------

// File: rtl/bit_op_ctrl_pkg.sv
// bit_op_pkg: opcodes, FSM state encoding and bit-memory bus constants
// shared by the bit-op controller, its ALU and the memory side.
package bit_op_pkg;

  localparam logic [2:0] OP_SETB   = 3'b000;
  localparam logic [2:0] OP_CLR    = 3'b001;
  localparam logic [2:0] OP_CPL    = 3'b010;
  localparam logic [2:0] OP_MOV_CB = 3'b011;  // MOV C,bit
  localparam logic [2:0] OP_MOV_BC = 3'b100;  // MOV bit,C
  localparam logic [2:0] OP_ANL    = 3'b101;
  localparam logic [2:0] OP_ORL    = 3'b110;
  localparam logic [2:0] OP_JBC    = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    EX   = 3'd2,
    WR   = 3'd3,
    DN   = 3'd4
  } state_t;

  localparam logic CS_SEL   = 1'b0;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/bit_op_ctrl_if.sv
// bit_op_ctrl_if: bit-memory port.
//   mem_CS   chip select, low = selected
//   mem_RW   high = read, low = write
//   mem_addr bit address
//   mem_din  write data to memory
//   mem_dout read data from memory (registered by the memory)
// master = controller, slave = memory.
interface bit_op_ctrl_if #(
  parameter int ADDRWIDTH = 3
);
  logic                 mem_CS;
  logic                 mem_RW;
  logic [ADDRWIDTH-1:0] mem_addr;
  logic                 mem_din;
  logic                 mem_dout;

  modport master (output mem_CS, mem_RW, mem_addr, mem_din, input mem_dout);
  modport slave  (input mem_CS, mem_RW, mem_addr, mem_din, output mem_dout);
endinterface

// File: rtl/bit_op_ctrl_alu.sv
// bit_op_alu: combinational evaluation of one 8051 bit instruction.
//   op          opcode
//   rd_bit      bit value read from memory
//   c_in        carry in
//   wdata       value to write back
//   c_out       resulting carry (c_in for ops that leave carry alone)
//   needs_read  op reads the bit first
//   needs_write op writes the bit
module bit_op_alu
  import bit_op_pkg::*;
(
  input  logic [2:0] op,
  input  logic       rd_bit,
  input  logic       c_in,
  output logic       wdata,
  output logic       c_out,
  output logic       needs_read,
  output logic       needs_write
);

  always_comb begin
    wdata       = rd_bit;
    c_out       = c_in;
    needs_read  = (op != OP_MOV_BC);
    needs_write = 1'b0;
    case (op)
      OP_SETB:   begin wdata = 1'b1;    needs_write = 1'b1; end
      OP_CLR:    begin wdata = 1'b0;    needs_write = 1'b1; end
      OP_CPL:    begin wdata = ~rd_bit; needs_write = 1'b1; end
      OP_MOV_CB: c_out = rd_bit;
      OP_MOV_BC: begin wdata = c_in;    needs_write = 1'b1; end
      OP_ANL:    c_out = c_in & rd_bit;
      OP_ORL:    c_out = c_in | rd_bit;
      OP_JBC:    begin wdata = 1'b0;    needs_write = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/bit_op_ctrl.sv
// bit_op_ctrl: initiator side of the bit-memory port. Accepts one bit
// instruction from the decoder, runs RD/EX/WR against the memory as the
// opcode requires, then pulses done for one cycle.
//   clk, rst   clock, synchronous active-high reset
//   req        start request (sampled only in IDLE)
//   op         opcode, latched with req
//   bit_addr   target bit, latched with req
//   c_in       carry, latched with req
//   busy       high outside IDLE
//   done       one-cycle completion pulse
//   c_out      resulting carry, valid with done
//   bit_val    bit read, valid with done for read ops
//   mem        bit-memory port (master side)
module bit_op_ctrl
  import bit_op_pkg::*;
#(
  parameter int ADDRWIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [2:0]           op,
  input  logic [ADDRWIDTH-1:0] bit_addr,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic                 c_out,
  output logic                 bit_val,
  bit_op_ctrl_if.master        mem
);

  state_t               state, state_nxt;
  logic [2:0]           op_r;
  logic [ADDRWIDTH-1:0] addr_r;
  logic                 c_r;
  logic                 wdata_r;

  logic [2:0] alu_op;
  logic       rd_bit;
  logic       alu_wdata, alu_cout, needs_read, needs_write;

  // Only a clean logic 1 counts; 0, x and z all read as 0.
  assign rd_bit = (mem.mem_dout === 1'b1);

  // In IDLE the branch decision must come from the incoming opcode; after
  // that the latched opcode drives the ALU.
  assign alu_op = (state == IDLE) ? op : op_r;

  bit_op_alu u_alu (
    .op          (alu_op),
    .rd_bit      (rd_bit),
    .c_in        (c_r),
    .wdata       (alu_wdata),
    .c_out       (alu_cout),
    .needs_read  (needs_read),
    .needs_write (needs_write)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = needs_read ? RD : WR;
      RD:      state_nxt = EX;
      EX:      state_nxt = needs_write ? WR : DN;
      WR:      state_nxt = DN;
      DN:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs: state register and latched operands only.
  always_comb begin
    busy         = (state != IDLE);
    done         = (state == DN);
    mem.mem_CS   = (state == RD || state == WR) ? CS_SEL : ~CS_SEL;
    mem.mem_RW   = (state == WR) ? RW_WRITE : RW_READ;
    mem.mem_addr = addr_r;
    mem.mem_din  = wdata_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r    <= '0;
      addr_r  <= '0;
      c_r     <= 1'b0;
      wdata_r <= 1'b0;
      c_out   <= 1'b0;
      bit_val <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          op_r    <= op;
          addr_r  <= bit_addr;
          c_r     <= c_in;
          // MOV bit,C skips EX, so its write data is loaded here; every
          // other op overwrites it in EX.
          wdata_r <= c_in;
        end
        EX: begin
          wdata_r <= alu_wdata;
          c_out   <= alu_cout;
          bit_val <= rd_bit;
        end
        WR: if (op_r == OP_MOV_BC) c_out <= c_r;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_op_ctrl.sv
// tb_bit_op_ctrl: bench for bit_op_ctrl with a behavioural bit memory and a
// transaction-level reference model (predicted result and bus timeline per
// accepted request), directed literal checks and randomized traffic.
module tb_bit_op_ctrl;
  import bit_op_pkg::*;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic [2:0]    op = '0;
  logic [AW-1:0] bit_addr = '0;
  logic          c_in = 1'b0;
  logic          busy, done, c_out, bit_val;

  bit_op_ctrl_if #(.ADDRWIDTH(AW)) mif ();

  bit_op_ctrl #(.ADDRWIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .op       (op),
    .bit_addr (bit_addr),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .c_out    (c_out),
    .bit_val  (bit_val),
    .mem      (mif.master)
  );

  always #5 clk = ~clk;

  // Bit memory: registered read, write at the edge ending a CS-low write cycle.
  logic [7:0] mem_arr = 8'b0000_1100;
  logic       dout_r  = 1'b0;
  always @(posedge clk) begin
    if (mif.mem_CS == 1'b0) begin
      if (mif.mem_RW) dout_r <= mem_arr[mif.mem_addr];
      else            mem_arr[mif.mem_addr] <= mif.mem_din;
    end
  end
  assign mif.mem_dout = dout_r;

  int n_chk  = 0;
  int n_fail = 0;
  int n      = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, n);
    end
  endtask

  // Reference model. Edge n is the n-th rising edge; "cycle n" follows it.
  // An op accepted at edge n0 occupies cycles n0..d, with done in cycle d,
  // a read cycle at n0 and a write cycle at d-1; the next accept is edge d+2.
  logic [7:0] ref_mem = 8'b0000_1100;
  bit         m_act = 1'b0;
  int         m_n0 = 0, m_d = 0, m_free = 0;
  logic [2:0] m_a = '0;
  bit         m_rd, m_wr, m_wd, m_co, m_bv;

  always @(posedge clk) begin : model
    bit b;
    int lat;
    n++;
    if (m_act && m_wr && n == m_d) ref_mem[m_a] = m_wd;
    if (rst) begin
      m_act  = 1'b0;
      m_free = n + 1;
    end else if (req && n >= m_free) begin
      b    = ref_mem[bit_addr];
      m_a  = bit_addr;
      m_rd = (op != OP_MOV_BC);
      m_wr = (op inside {OP_SETB, OP_CLR, OP_CPL, OP_MOV_BC, OP_JBC});
      m_co = c_in;
      m_bv = b;
      m_wd = b;
      case (op)
        OP_SETB:   m_wd = 1'b1;
        OP_CLR:    m_wd = 1'b0;
        OP_CPL:    m_wd = !b;
        OP_MOV_CB: m_co = b;
        OP_MOV_BC: m_wd = c_in;
        OP_ANL:    m_co = c_in & b;
        OP_ORL:    m_co = c_in | b;
        default:   m_wd = 1'b0;  // JBC
      endcase
      lat    = m_rd ? (m_wr ? 4 : 3) : 2;
      m_n0   = n;
      m_d    = n + lat - 1;
      m_free = m_d + 2;
      m_act  = 1'b1;
    end
  end

  always @(negedge clk) begin : cmp
    bit eb, ed, erd, ewr;
    if (n > 0) begin
      eb  = m_act && n >= m_n0 && n <= m_d;
      ed  = m_act && n == m_d;
      erd = m_act && m_rd && n == m_n0;
      ewr = m_act && m_wr && n == m_d - 1;
      chk("busy", busy, eb);
      chk("done", done, ed);
      chk("cs", mif.mem_CS, !(erd || ewr));
      if (erd) begin
        chk("rd_rw", mif.mem_RW, 1);
        chk("rd_addr", mif.mem_addr, m_a);
      end
      if (ewr) begin
        chk("wr_rw", mif.mem_RW, 0);
        chk("wr_addr", mif.mem_addr, m_a);
        chk("wr_din", mif.mem_din, m_wd);
      end
      if (ed) begin
        chk("c_out", c_out, m_co);
        if (m_rd) chk("bit_val", bit_val, m_bv);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 20) begin @(negedge clk); t++; end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [AW-1:0] a, input logic c,
                       output logic co, output logic bv);
    int t = 0;
    wait_idle();
    req = 1'b1; op = o; bit_addr = a; c_in = c;
    @(negedge clk);
    req = 1'b0;
    while (!done && t < 10) begin @(negedge clk); t++; end
    if (!done) chk("done_timeout", 0, 1);
    co = c_out;
    bv = bit_val;
    @(negedge clk);
  endtask

  logic co, bv;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cout", c_out, 0);
    chk("rst_bitval", bit_val, 0);
    chk("rst_cs", mif.mem_CS, 1);
    chk("rst_rw", mif.mem_RW, 1);
    chk("rst_addr", mif.mem_addr, 0);
    chk("rst_din", mif.mem_din, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op(OP_SETB, 3'd5, 1'b0, co, bv);   chk("setb5_cout", co, 0);
    do_op(OP_MOV_CB, 3'd5, 1'b0, co, bv); chk("movcb5", co, 1);
    do_op(OP_CPL, 3'd2, 1'b0, co, bv);
    do_op(OP_MOV_CB, 3'd2, 1'b1, co, bv); chk("cpl2_first", co, 0);
    do_op(OP_ANL, 3'd2, 1'b1, co, bv);    chk("anl", co, 0);
    do_op(OP_CPL, 3'd2, 1'b0, co, bv);
    do_op(OP_MOV_CB, 3'd2, 1'b0, co, bv); chk("cpl2_second", co, 1);
    do_op(OP_ORL, 3'd2, 1'b0, co, bv);    chk("orl", co, 1);
    do_op(OP_MOV_BC, 3'd7, 1'b1, co, bv); chk("movbc_cout", co, 1);
    do_op(OP_MOV_CB, 3'd7, 1'b0, co, bv); chk("movbc7", co, 1);
    do_op(OP_JBC, 3'd3, 1'b0, co, bv);    chk("jbc_bv", bv, 1); chk("jbc_co", co, 0);
    do_op(OP_MOV_CB, 3'd3, 1'b1, co, bv); chk("jbc_cleared", co, 0);
    do_op(OP_JBC, 3'd3, 1'b1, co, bv);    chk("jbc0_bv", bv, 0); chk("jbc0_co", co, 1);
    do_op(OP_MOV_CB, 3'd3, 1'b1, co, bv); chk("jbc0_still0", co, 0);

    // Reset during EX of SETB: no write, no done.
    wait_idle();
    req = 1'b1; op = OP_SETB; bit_addr = 3'd6; c_in = 1'b0;
    @(negedge clk); req = 1'b0;   // RD
    @(negedge clk); rst = 1'b1;   // EX
    @(negedge clk); rst = 1'b0;
    chk("rst_ex_cs", mif.mem_CS, 1);
    chk("rst_ex_busy", busy, 0);
    do_op(OP_MOV_CB, 3'd6, 1'b0, co, bv); chk("rst_ex_nowrite", co, 0);

    // Reset during WR of SETB: write still lands, no done.
    wait_idle();
    req = 1'b1; op = OP_SETB; bit_addr = 3'd6; c_in = 1'b0;
    @(negedge clk); req = 1'b0;   // RD
    @(negedge clk);               // EX
    @(negedge clk); rst = 1'b1;   // WR
    @(negedge clk); rst = 1'b0;
    chk("rst_wr_busy", busy, 0);
    do_op(OP_MOV_CB, 3'd6, 1'b0, co, bv); chk("rst_wr_landed", co, 1);

    // req held high with changing operands.
    wait_idle();
    req = 1'b1;
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7)); bit_addr = 3'($urandom_range(0, 7));
      c_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    req = 1'b0;

    // Random req pulses, including during busy, and sparse resets.
    for (int i = 0; i < 300; i++) begin
      req = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7)); bit_addr = 3'($urandom_range(0, 7));
      c_in = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 40) == 0);
      @(negedge clk);
    end
    req = 1'b0; rst = 1'b0;

    for (int i = 0; i < 60; i++)
      do_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), co, bv);

    repeat (8) @(negedge clk);
    for (int a = 0; a < 8; a++) chk("mem_final", mem_arr[a], ref_mem[a]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
